// File: rtl/mmio_bridge.sv
// Data-side address decoder and I/O register block for the RV32I core:
// routes loads/stores to data RAM, a keyboard FIFO, a ms timer or the LED register.
module mmio_bridge #(
  parameter int CLK_PER_MS = 50000,
  parameter int KBD_DEPTH  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_op,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [2:0]  ram_op,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  input  logic [7:0]  kbd_code,
  input  logic        kbd_valid,
  output logic [15:0] led
);

  localparam int PTR_W   = $clog2(KBD_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int PRESC_W = $clog2(CLK_PER_MS);
  localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(KBD_DEPTH);
  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(CLK_PER_MS - 1);

  typedef enum logic [2:0] {
    REG_RAM,
    REG_KBD,
    REG_TIMER,
    REG_LED,
    REG_NONE
  } region_e;

  region_e region;
  logic [1:0] offset;
  logic ldEn;

  logic [7:0]       fifoMem [KBD_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             kbdNonEmpty, kbdFull, kbdPop, kbdPush, ovfSet, ovfClr;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        ms_q, ms_d;
  logic               timerWr;

  logic [15:0] led_q, led_d;

  logic [31:0] ioRdata;
  logic        rdSelRam_q, rdSelRam_d;
  logic [31:0] rdVal_q, rdVal_d;

  always_comb begin
    region = REG_NONE;
    case (cpu_addr[31:20])
      12'h001: region = REG_RAM;
      12'h008: region = REG_KBD;
      12'h009: region = REG_TIMER;
      12'h00A: region = REG_LED;
      default: region = REG_NONE;
    endcase
  end

  assign offset = cpu_addr[3:2];
  // A simultaneous store wins, so loads only count when cpu_we is low.
  assign ldEn   = cpu_re & ~cpu_we;

  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_op    = cpu_op;
  assign ram_we    = cpu_we & (region == REG_RAM) & ~reset;

  assign kbdNonEmpty = (count_q != '0);
  assign kbdFull     = (count_q == DEPTH_C);
  assign kbdPop      = ldEn & (region == REG_KBD) & (offset == 2'd0) & kbdNonEmpty;
  assign kbdPush     = kbd_valid & (~kbdFull | kbdPop);
  assign ovfSet      = kbd_valid & kbdFull & ~kbdPop;
  assign ovfClr      = ldEn & (region == REG_KBD) & (offset == 2'd1);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (kbdPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (kbdPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({kbdPush, kbdPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ovfSet)      ovf_d = 1'b1;
    else if (ovfClr) ovf_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (kbdPush && !reset) fifoMem[wrPtr_q] <= kbd_code;
  end

  assign timerWr = cpu_we & (region == REG_TIMER) & (cpu_op == 3'b010);

  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    if (timerWr) begin
      presc_d = '0;
      ms_d    = cpu_wdata;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      ms_d    = ms_q + 32'd1;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  always_comb begin
    led_d = led_q;
    if (cpu_we && region == REG_LED) begin
      case (cpu_op)
        3'b000:        led_d[7:0] = cpu_wdata[7:0];
        3'b001, 3'b010: led_d     = cpu_wdata[15:0];
        default:       led_d      = led_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      ms_q    <= '0;
      led_q   <= '0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

  // I/O read values are raw 32-bit words; width/sign only apply to RAM.
  always_comb begin
    ioRdata = '0;
    case (region)
      REG_KBD: begin
        if (offset == 2'd0)      ioRdata = kbdNonEmpty ? {24'b0, fifoMem[rdPtr_q]} : 32'd0;
        else if (offset == 2'd1) ioRdata = {30'b0, ovf_q, kbdNonEmpty};
        else                     ioRdata = '0;
      end
      REG_TIMER: ioRdata = ms_q;
      REG_LED:   ioRdata = {16'b0, led_q};
      default:   ioRdata = '0;
    endcase
  end

  always_comb begin
    rdSelRam_d = rdSelRam_q;
    rdVal_d    = rdVal_q;
    if (ldEn) begin
      rdSelRam_d = (region == REG_RAM);
      rdVal_d    = ioRdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdSelRam_q <= 1'b0;
      rdVal_q    <= '0;
    end else begin
      rdSelRam_q <= rdSelRam_d;
      rdVal_q    <= rdVal_d;
    end
  end

  // RAM registers its own read data on the same edge, so it is muxed in live.
  assign cpu_rdata = rdSelRam_q ? ram_rdata : rdVal_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge with a fast timer and a
// 16-entry keyboard FIFO.
module tb_mmio_bridge;

  localparam int CLK_PER_MS = 4;
  localparam int KBD_DEPTH  = 16;

  localparam logic [31:0] KBD_DATA   = 32'h008FFFF0;
  localparam logic [31:0] KBD_STATUS = 32'h00800004;
  localparam logic [31:0] TIMER_A    = 32'h00900000;
  localparam logic [31:0] LED_A      = 32'h00A00000;
  localparam logic [31:0] RAM_A      = 32'h00100010;
  localparam logic [31:0] RAM_XOR    = 32'hA5A5A5A5;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_op;
  logic        cpu_we, cpu_re;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [2:0]  ram_op;
  logic        ram_we;
  logic [7:0]  kbd_code;
  logic        kbd_valid;
  logic [15:0] led;

  int checkCount = 0;
  int passCount  = 0;
  int ramWeCount = 0;
  int weBefore;

  mmio_bridge #(.CLK_PER_MS(CLK_PER_MS), .KBD_DEPTH(KBD_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_op(cpu_op),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_op(ram_op),
    .ram_we(ram_we), .ram_rdata(ram_rdata),
    .kbd_code(kbd_code), .kbd_valid(kbd_valid), .led(led)
  );

  always #5 clock = ~clock;

  // Registered RAM stand-in whose read data is a known function of the address.
  always @(posedge clock) ram_rdata <= ram_addr ^ RAM_XOR;

  always @(negedge clock) if (ram_we) ramWeCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] op,
                               input logic we, input logic re, input logic kv, input logic [7:0] code);
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_op    = op;
    cpu_we    = we;
    cpu_re    = re;
    kbd_valid = kv;
    kbd_code  = code;
    @(posedge clock);
    #1;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    kbd_valid = 1'b0;
  endtask

  task automatic loadWord(input logic [31:0] addr);
    applyStimulus(addr, 32'd0, 3'b010, 1'b0, 1'b1, 1'b0, 8'd0);
  endtask

  task automatic storeWord(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] op);
    applyStimulus(addr, data, op, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic pushCode(input logic [7:0] code);
    applyStimulus(32'd0, 32'd0, 3'b010, 1'b0, 1'b0, 1'b1, code);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'd0, 32'd0, 3'b010, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_op = 3'b010;
    cpu_we = 1'b0; cpu_re = 1'b0; kbd_valid = 1'b0; kbd_code = '0;

    // Reset must override pending stores and keyboard pushes.
    applyStimulus(LED_A, 32'h0000FFFF, 3'b010, 1'b1, 1'b0, 1'b1, 8'h11);
    applyStimulus(RAM_A, 32'h12345678, 3'b010, 1'b1, 1'b0, 1'b1, 8'h22);
    checkOutput("reset_led", {16'b0, led}, 32'h0);
    checkOutput("reset_rdata", cpu_rdata, 32'h0);
    checkOutput("reset_ram_we", ramWeCount, 32'd0);
    reset = 1'b0;
    loadWord(KBD_STATUS);
    checkOutput("reset_status", cpu_rdata, 32'h0);
    loadWord(KBD_DATA);
    checkOutput("reset_data_empty", cpu_rdata, 32'h0);

    // Timer from a fresh reset: ms steps every 4 edges.
    reset = 1'b1;
    idleCycles(1);
    reset = 1'b0;
    idleCycles(11);
    loadWord(TIMER_A);
    checkOutput("timer_ms2", cpu_rdata, 32'd2);
    loadWord(TIMER_A | 32'h8);
    checkOutput("timer_ms3", cpu_rdata, 32'd3);
    storeWord(TIMER_A | 32'h4, 32'hFFFFFFFF, 3'b010);
    loadWord(TIMER_A);
    checkOutput("timer_sw_max", cpu_rdata, 32'hFFFFFFFF);
    idleCycles(3);
    loadWord(TIMER_A);
    checkOutput("timer_wrap", cpu_rdata, 32'h0);
    storeWord(TIMER_A, 32'h12345678, 3'b000);
    loadWord(TIMER_A);
    checkOutput("timer_sb_ignored", cpu_rdata, 32'h0);

    // FIFO ordering and empty read.
    pushCode(8'h1C); pushCode(8'h32); pushCode(8'h21);
    loadWord(KBD_STATUS);
    checkOutput("fifo_status1", cpu_rdata, 32'h1);
    loadWord(KBD_DATA); checkOutput("fifo_rd0", cpu_rdata, 32'h1C);
    loadWord(KBD_DATA); checkOutput("fifo_rd1", cpu_rdata, 32'h32);
    loadWord(KBD_DATA); checkOutput("fifo_rd2", cpu_rdata, 32'h21);
    loadWord(KBD_DATA); checkOutput("fifo_rd_empty", cpu_rdata, 32'h0);
    loadWord(KBD_STATUS); checkOutput("fifo_status0", cpu_rdata, 32'h0);

    // Overflow: 17 pushes into 16 entries, last code lost.
    for (int i = 0; i <= 16; i++) pushCode(8'(i));
    loadWord(KBD_STATUS); checkOutput("ovf_status3", cpu_rdata, 32'h3);
    loadWord(KBD_STATUS); checkOutput("ovf_cleared", cpu_rdata, 32'h1);
    for (int i = 0; i < 16; i++) begin
      loadWord(KBD_DATA);
      checkOutput($sformatf("ovf_rd%0d", i), cpu_rdata, 32'(i));
    end
    loadWord(KBD_DATA); checkOutput("ovf_lost", cpu_rdata, 32'h0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) pushCode(8'(8'h40 + i));
    applyStimulus(KBD_DATA, 32'd0, 3'b010, 1'b0, 1'b1, 1'b1, 8'hAA);
    checkOutput("full_pp_head", cpu_rdata, 32'h40);
    loadWord(KBD_STATUS); checkOutput("full_pp_no_ovf", cpu_rdata, 32'h1);
    for (int i = 1; i < 16; i++) begin
      loadWord(KBD_DATA);
      checkOutput($sformatf("full_rd%0d", i), cpu_rdata, 32'(8'h40 + i));
    end
    loadWord(KBD_DATA); checkOutput("full_last_aa", cpu_rdata, 32'hAA);
    loadWord(KBD_DATA); checkOutput("full_drained", cpu_rdata, 32'h0);

    // Push and pop together while empty.
    applyStimulus(KBD_DATA, 32'd0, 3'b010, 1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("empty_pp_zero", cpu_rdata, 32'h0);
    loadWord(KBD_DATA); checkOutput("empty_pp_5a", cpu_rdata, 32'h5A);
    loadWord(KBD_DATA); checkOutput("empty_pp_after", cpu_rdata, 32'h0);

    // RAM decode and pass-through.
    weBefore = ramWeCount;
    storeWord(RAM_A, 32'hCAFEF00D, 3'b010);
    checkOutput("ram_we_pulse", ramWeCount - weBefore, 32'd1);
    loadWord(RAM_A);
    checkOutput("ram_load", cpu_rdata, 32'hA5B5A5B5);

    // LED register writes.
    weBefore = ramWeCount;
    storeWord(LED_A, 32'h1234ABCD, 3'b010);
    checkOutput("led_sw", {16'b0, led}, 32'h0000ABCD);
    storeWord(LED_A, 32'h00000077, 3'b000);
    checkOutput("led_sb", {16'b0, led}, 32'h0000AB77);
    checkOutput("led_no_ram_we", ramWeCount - weBefore, 32'd0);
    loadWord(LED_A | 32'hC);
    checkOutput("led_load", cpu_rdata, 32'h0000AB77);
    loadWord(32'h00500000);
    checkOutput("unmapped_load", cpu_rdata, 32'h0);

    // No side effects without a genuine load; read data holds.
    pushCode(8'h99);
    loadWord(KBD_STATUS); checkOutput("nopop_status", cpu_rdata, 32'h1);
    applyStimulus(KBD_DATA, 32'd0, 3'b010, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("hold_re_low", cpu_rdata, 32'h1);
    loadWord(KBD_DATA); checkOutput("nopop_data", cpu_rdata, 32'h99);
    pushCode(8'h98);
    applyStimulus(KBD_DATA, 32'd0, 3'b010, 1'b1, 1'b1, 1'b0, 8'd0);
    checkOutput("we_re_hold", cpu_rdata, 32'h99);
    loadWord(KBD_DATA); checkOutput("we_re_nopop", cpu_rdata, 32'h98);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
